// File: rtl/lut_checker_mc_if.sv
// lut_checker_mc_if: stimulus and result bundle between a bench and lut_checker_mc
// master drives enable, tol, exp_valid, exp_data, res_data and observes the results;
// slave (the checker) observes the stimulus and drives err, war, delta, min_delta, max_delta,
// err_cnt, war_cnt, cmp_cnt, first_err_valid, first_err_ch and first_err_idx.
interface lut_checker_mc_if #(
    parameter int NCH = 4,
    parameter int W   = 16,
    parameter int CW  = 16
);
    localparam int DW = W + 1;
    localparam int FW = (NCH > 1) ? $clog2(NCH) : 1;
    logic              enable;
    logic [W-1:0]      tol;
    logic              exp_valid;
    logic [NCH*W-1:0]  exp_data;
    logic [NCH*W-1:0]  res_data;
    logic [NCH-1:0]    err;
    logic [NCH-1:0]    war;
    logic [NCH*DW-1:0] delta;
    logic [NCH*DW-1:0] min_delta;
    logic [NCH*DW-1:0] max_delta;
    logic [NCH*CW-1:0] err_cnt;
    logic [NCH*CW-1:0] war_cnt;
    logic [CW-1:0]     cmp_cnt;
    logic              first_err_valid;
    logic [FW-1:0]     first_err_ch;
    logic [CW-1:0]     first_err_idx;

    modport master (
        output enable, tol, exp_valid, exp_data, res_data,
        input  err, war, delta, min_delta, max_delta, err_cnt, war_cnt, cmp_cnt,
               first_err_valid, first_err_ch, first_err_idx
    );

    modport slave (
        input  enable, tol, exp_valid, exp_data, res_data,
        output err, war, delta, min_delta, max_delta, err_cnt, war_cnt, cmp_cnt,
               first_err_valid, first_err_ch, first_err_idx
    );
endinterface

// File: rtl/lut_checker_mc.sv
// lut_checker_mc: multi-channel fixed-point result checker with latency alignment and statistics
// clk: clock; arst: asynchronous active-high reset; srst: synchronous active-high clear.
// bus (slave): enable gates compares, tol is the warning tolerance in LSBs, exp_valid/exp_data are
// delayed LAT cycles to line up with res_data. Results: per-channel err/war/delta of the last compare,
// signed min/max delta, saturating err/war counts, cmp_cnt and capture of the first error.
module lut_checker_mc #(
    parameter int NCH = 4,
    parameter int W   = 16,
    parameter int LAT = 2,
    parameter int CW  = 16
) (
    input logic             clk,
    input logic             arst,
    input logic             srst,
    lut_checker_mc_if.slave bus
);
    localparam int DW = W + 1;
    localparam int FW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CW-1:0] CMAX = '1;

    logic             d_valid;
    logic [NCH*W-1:0] d_data;
    logic             fire;
    logic [NCH-1:0]   err_n;
    logic [FW-1:0]    ch_n;
    logic             init;
    logic [CW-1:0]    cmp_cnt;
    logic             first_valid;
    logic [FW-1:0]    first_ch;
    logic [CW-1:0]    first_idx;

    // Only the valid bits are reset; stale data behind a cleared valid is never compared.
    generate
        if (LAT == 0) begin : g_direct
            assign d_valid = bus.exp_valid;
            assign d_data  = bus.exp_data;
        end else begin : g_delay
            logic [LAT-1:0]   v;
            logic [NCH*W-1:0] d [LAT];
            always_ff @(posedge clk or posedge arst)
                if (arst) v <= '0;
                else if (srst) v <= '0;
                else v <= LAT'({v, bus.exp_valid});
            always_ff @(posedge clk) begin
                d[0] <= bus.exp_data;
                for (int i = 1; i < LAT; i++) d[i] <= d[i-1];
            end
            assign d_valid = v[LAT-1];
            assign d_data  = d[LAT-1];
        end
    endgenerate

    assign fire = d_valid && bus.enable;

    genvar k;
    for (k = 0; k < NCH; k++) begin : g_ch
        logic [W-1:0]  e, r;
        logic [DW-1:0] dn, mag, dq, mn, mx;
        logic          wn, eq, wq;
        logic [CW-1:0] ec, wc;
        assign e  = d_data[k*W +: W];
        assign r  = bus.res_data[k*W +: W];
        assign dn = {e[W-1], e} - {r[W-1], r};
        // dn lies in [-(2^W-1), 2^W-1], so its negation always fits in DW bits
        assign mag      = dn[W] ? -dn : dn;
        assign err_n[k] = mag > {1'b0, bus.tol};
        assign wn       = (mag != '0) && !err_n[k];
        always_ff @(posedge clk or posedge arst)
            if (arst) {eq, wq, dq, mn, mx, ec, wc} <= '0;
            else if (srst) {eq, wq, dq, mn, mx, ec, wc} <= '0;
            else if (fire) begin
                eq <= err_n[k];
                wq <= wn;
                dq <= dn;
                if (!init || $signed(dn) < $signed(mn)) mn <= dn;
                if (!init || $signed(dn) > $signed(mx)) mx <= dn;
                ec <= (ec == CMAX) ? ec : ec + CW'(err_n[k]);
                wc <= (wc == CMAX) ? wc : wc + CW'(wn);
            end
        assign bus.err[k]                 = eq;
        assign bus.war[k]                 = wq;
        assign bus.delta[k*DW +: DW]      = dq;
        assign bus.min_delta[k*DW +: DW]  = mn;
        assign bus.max_delta[k*DW +: DW]  = mx;
        assign bus.err_cnt[k*CW +: CW]    = ec;
        assign bus.war_cnt[k*CW +: CW]    = wc;
    end

    // Scanning downwards leaves the lowest erroring channel in ch_n.
    always_comb begin
        ch_n = '0;
        for (int i = NCH - 1; i >= 0; i--) if (err_n[i]) ch_n = FW'(i);
    end

    always_ff @(posedge clk or posedge arst)
        if (arst) {init, cmp_cnt, first_valid, first_ch, first_idx} <= '0;
        else if (srst) {init, cmp_cnt, first_valid, first_ch, first_idx} <= '0;
        else if (fire) begin
            init    <= 1'b1;
            cmp_cnt <= (cmp_cnt == CMAX) ? cmp_cnt : cmp_cnt + CW'(1);
            if (!first_valid && |err_n) begin
                first_valid <= 1'b1;
                first_ch    <= ch_n;
                first_idx   <= cmp_cnt;
            end
        end

    assign bus.cmp_cnt         = cmp_cnt;
    assign bus.first_err_valid = first_valid;
    assign bus.first_err_ch    = first_ch;
    assign bus.first_err_idx   = first_idx;
endmodule

// File: tb/tb_lut_checker_mc.sv
// tb_lut_checker_mc: scoreboard bench for lut_checker_mc against an integer reference model
// The driver plans each cycle, steps the model and queues the expected outputs; the monitor pops
// one expectation per negedge (and one on each arst assertion) and compares every output.
module tb_lut_checker_mc;
    localparam int NCH  = 4;
    localparam int W    = 16;
    localparam int LAT  = 2;
    localparam int CW   = 6;
    localparam int DW   = W + 1;
    localparam int FW   = 2;
    localparam int MAXC = (1 << CW) - 1;

    typedef struct packed {
        logic [NCH-1:0]    err;
        logic [NCH-1:0]    war;
        logic [NCH*DW-1:0] delta;
        logic [NCH*DW-1:0] mn;
        logic [NCH*DW-1:0] mx;
        logic [NCH*CW-1:0] ec;
        logic [NCH*CW-1:0] wc;
        logic [CW-1:0]     cmp;
        logic              fev;
        logic [FW-1:0]     fch;
        logic [CW-1:0]     fidx;
    } snap_t;

    typedef struct packed {
        int               due;
        logic [NCH*W-1:0] v;
    } ent_t;

    logic clk;
    logic arst;
    logic srst;
    lut_checker_mc_if #(.NCH(NCH), .W(W), .CW(CW)) b ();

    lut_checker_mc #(.NCH(NCH), .W(W), .LAT(LAT), .CW(CW)) dut (
        .clk (clk),
        .arst(arst),
        .srst(srst),
        .bus (b.slave)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    snap_t sb[$];
    ent_t  fl[$];
    ent_t  rq[$];
    int    cyc;
    int    total;
    int    bad;
    bit    mon_on;

    int m_dl[NCH], m_mn[NCH], m_mx[NCH], m_ec[NCH], m_wc[NCH];
    bit m_er[NCH], m_wr[NCH];
    int m_cmp, m_fch, m_fidx;
    bit m_fev, m_init;

    function automatic int sat(int x);
        return x > MAXC ? MAXC : x;
    endfunction

    function automatic void m_clear();
        for (int k = 0; k < NCH; k++) begin
            m_dl[k] = 0; m_mn[k] = 0; m_mx[k] = 0; m_ec[k] = 0; m_wc[k] = 0;
            m_er[k] = 0; m_wr[k] = 0;
        end
        m_cmp = 0; m_fch = 0; m_fidx = 0; m_fev = 0; m_init = 0;
        fl.delete();
    endfunction

    function automatic void m_compare(logic [NCH*W-1:0] e, logic [NCH*W-1:0] r, int tl);
        int d, m, fc;
        fc = -1;
        for (int k = 0; k < NCH; k++) begin
            d = int'($signed(e[k*W +: W])) - int'($signed(r[k*W +: W]));
            m = d < 0 ? -d : d;
            m_er[k] = m > tl;
            m_wr[k] = m != 0 && m <= tl;
            m_dl[k] = d;
            if (!m_init || d < m_mn[k]) m_mn[k] = d;
            if (!m_init || d > m_mx[k]) m_mx[k] = d;
            if (m_er[k]) m_ec[k] = sat(m_ec[k] + 1);
            if (m_wr[k]) m_wc[k] = sat(m_wc[k] + 1);
            if (m_er[k] && fc < 0) fc = k;
        end
        if (!m_fev && fc >= 0) begin
            m_fev = 1; m_fch = fc; m_fidx = m_cmp;
        end
        m_cmp = sat(m_cmp + 1);
        m_init = 1;
    endfunction

    function automatic void m_step(logic ev, logic [NCH*W-1:0] ed, logic [NCH*W-1:0] rd,
                                   logic en, logic [W-1:0] tl, logic sr);
        ent_t x;
        cyc++;
        if (sr) begin
            m_clear();
            return;
        end
        x.due = cyc + LAT;
        x.v = ed;
        if (ev) fl.push_back(x);
        if (fl.size() != 0 && fl[0].due == cyc) begin
            x = fl.pop_front();
            if (en) m_compare(x.v, rd, int'(tl));
        end
    endfunction

    function automatic snap_t snap();
        snap_t s;
        for (int k = 0; k < NCH; k++) begin
            s.err[k] = m_er[k];
            s.war[k] = m_wr[k];
            s.delta[k*DW +: DW] = DW'(m_dl[k]);
            s.mn[k*DW +: DW] = DW'(m_mn[k]);
            s.mx[k*DW +: DW] = DW'(m_mx[k]);
            s.ec[k*CW +: CW] = CW'(m_ec[k]);
            s.wc[k*CW +: CW] = CW'(m_wc[k]);
        end
        s.cmp = CW'(m_cmp);
        s.fev = m_fev;
        s.fch = FW'(m_fch);
        s.fidx = CW'(m_fidx);
        return s;
    endfunction

    function automatic logic [NCH*W-1:0] rep(logic [W-1:0] x);
        return {NCH{x}};
    endfunction

    function automatic logic [NCH*W-1:0] rnd_vec();
        logic [NCH*W-1:0] r;
        for (int k = 0; k < NCH; k++) r[k*W +: W] = W'($urandom);
        return r;
    endfunction

    function automatic logic [NCH*W-1:0] next_res();
        logic [NCH*W-1:0] r;
        ent_t x;
        r = rnd_vec();
        while (rq.size() != 0 && rq[0].due < cyc + 1) x = rq.pop_front();
        if (rq.size() != 0 && rq[0].due == cyc + 1) begin
            x = rq.pop_front();
            r = x.v;
        end
        return r;
    endfunction

    task automatic go(input logic ev, input logic [NCH*W-1:0] ed, input logic en,
                      input logic [W-1:0] tl, input logic sr, input logic [NCH-1:0] msk, input int off);
        ent_t x;
        logic [NCH*W-1:0] rd;
        x.due = cyc + 1 + LAT;
        x.v = ed;
        for (int k = 0; k < NCH; k++) if (msk[k]) x.v[k*W +: W] = ed[k*W +: W] + W'(off);
        if (ev && !sr) rq.push_back(x);
        rd = next_res();
        arst = 0;
        srst = sr;
        b.enable = en;
        b.tol = tl;
        b.exp_valid = ev;
        b.exp_data = ed;
        b.res_data = rd;
        m_step(ev, ed, rd, en, tl, sr);
        sb.push_back(snap());
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic [W-1:0] tl, input logic en);
        repeat (n) go(1'b0, '0, en, tl, 1'b0, '0, 0);
    endtask

    task automatic do_arst();
        srst = 0;
        b.enable = 1;
        b.exp_valid = 1;
        b.exp_data = rnd_vec();
        b.res_data = rnd_vec();
        cyc++;
        m_clear();
        sb.push_back(snap());
        sb.push_back(snap());
        @(negedge clk);
        #2;
        arst = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    initial begin
        snap_t s;
        forever begin
            @(negedge clk or posedge arst);
            #1;
            if (mon_on) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL scoreboard_empty at %0t: got 0 entries expected 1", $time);
                end else begin
                    s = sb.pop_front();
                    chk("err", 128'(b.err), 128'(s.err));
                    chk("war", 128'(b.war), 128'(s.war));
                    chk("delta", 128'(b.delta), 128'(s.delta));
                    chk("min_delta", 128'(b.min_delta), 128'(s.mn));
                    chk("max_delta", 128'(b.max_delta), 128'(s.mx));
                    chk("err_cnt", 128'(b.err_cnt), 128'(s.ec));
                    chk("war_cnt", 128'(b.war_cnt), 128'(s.wc));
                    chk("cmp_cnt", 128'(b.cmp_cnt), 128'(s.cmp));
                    chk("first_err_valid", 128'(b.first_err_valid), 128'(s.fev));
                    chk("first_err_ch", 128'(b.first_err_ch), 128'(s.fch));
                    chk("first_err_idx", 128'(b.first_err_idx), 128'(s.fidx));
                end
            end
        end
    end

    initial begin
        logic [NCH*W-1:0] c;
        int off;
        total = 0;
        bad = 0;
        mon_on = 0;
        cyc = 0;
        arst = 1;
        srst = 0;
        b.enable = 0;
        b.tol = 0;
        b.exp_valid = 0;
        b.exp_data = '0;
        b.res_data = '0;
        c = rep(16'h1234);
        repeat (2) @(posedge clk);
        #1;
        m_clear();
        sb.push_back(snap());
        mon_on = 1;
        // exact matches
        repeat (10) go(1, c, 1, 1, 0, '0, 0);
        idle(LAT + 1, 1, 1);
        // warning then error on channel 2
        go(1, c, 1, 1, 0, 4'b0100, -1);
        idle(LAT + 1, 1, 1);
        go(1, c, 1, 1, 0, 4'b0100, 3);
        idle(LAT + 1, 1, 1);
        // first-error capture: channels 1 and 3 together, channel 0 later
        go(0, '0, 1, 1, 1, '0, 0);
        go(1, c, 1, 1, 0, '0, 0);
        go(1, c, 1, 1, 0, 4'b1010, 5);
        go(1, c, 1, 1, 0, '0, 0);
        go(1, c, 1, 1, 0, 4'b0001, -7);
        idle(LAT + 1, 1, 1);
        // extreme deltas and tolerance boundaries
        go(1, rep(16'h7FFF), 1, 16'hFFFE, 0, '1, 1);
        idle(LAT + 1, 16'hFFFE, 1);
        go(1, rep(16'h7FFF), 1, 16'hFFFF, 0, '1, 1);
        idle(LAT + 1, 16'hFFFF, 1);
        go(1, rep(16'h8000), 1, 0, 0, '1, -1);
        idle(LAT + 1, 0, 1);
        go(1, c, 1, 0, 0, 4'b0001, 1);
        idle(LAT + 1, 0, 1);
        // counter saturation, enable gating, srst reload
        go(0, '0, 1, 1, 1, '0, 0);
        repeat (MAXC + 1 + 5) go(1, c, 1, 1, 0, 4'b0001, 5);
        idle(LAT + 1, 1, 1);
        repeat (3) go(1, c, 0, 1, 0, 4'b0110, 9);
        idle(LAT + 1, 1, 0);
        go(0, '0, 1, 1, 1, '0, 0);
        go(1, c, 1, 1, 0, 4'b0001, 2);
        go(1, c, 1, 1, 0, 4'b0010, -1);
        idle(LAT + 1, 1, 1);
        // asynchronous reset with the delay line full
        repeat (3) go(1, c, 1, 1, 0, '1, 2);
        do_arst();
        idle(LAT + 3, 1, 1);
        // randomized traffic
        repeat (400) begin
            off = int'($urandom_range(0, 8)) - 4;
            if ($urandom_range(0, 9) == 0) off = int'($urandom_range(0, 65535));
            go($urandom_range(0, 3) != 0, rnd_vec(), $urandom_range(0, 7) != 0,
               W'($urandom_range(0, 5)), $urandom_range(0, 60) == 0, NCH'($urandom), off);
        end
        idle(LAT + 2, 1, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
